// File: rtl/cook_sequencer.sv
// cook_sequencer
//   Sequences one microwave cook cycle. It loads the cook time, counts it down
//   once per cook second, and gates the magnetron according to the power
//   setting. It also handles the door interlock, pause/resume and cancel.
//
//   Parameters
//     TICKS_PER_SEC : clk cycles per cook second (>=1)
//     DUTY_PERIOD   : half-power duty window in cook seconds (even, >=2)
//
//   Ports
//     clk            in   system clock, rising edge
//     rst_n          in   synchronous active-low reset
//     power          in   1 = FULL, 0 = HALF
//     timer[6:0]     in   requested cook time in seconds
//     door_status    in   1 = closed, 0 = open
//     start_button   in   start/resume request (level)
//     cancel_button  in   cancel request (level)
//     magnetron_on   out  magnetron enable (combinational door gating)
//     time_remaining out  seconds left
//     state[1:0]     out  0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
//     done_pulse     out  one-cycle completion pulse
//
//   Optional feature (macro COOK_ADD30_EN)
//     When the macro is defined, a rising edge of start_button during COOK
//     adds 30 s to the remaining time, saturating at 127.
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 1,
    parameter int DUTY_PERIOD   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power,
    input  logic [6:0] timer,
    input  logic       door_status,
    input  logic       start_button,
    input  logic       cancel_button,
    output logic       magnetron_on,
    output logic [6:0] time_remaining,
    output logic [1:0] state,
    output logic       done_pulse
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int DW = $clog2(DUTY_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] duty_phase;
    logic [6:0]    time_q;
    logic          done_q;

    logic          tick_wrap;
    logic          load_req;
    logic          add_req;
    logic [7:0]    add_sum;
    logic [6:0]    add_sat;

    assign tick_wrap = (tick_cnt == TW'(TICKS_PER_SEC - 1));
    assign load_req  = !cancel_button && start_button && door_status && (timer != 7'd0);
    assign add_sum   = {1'b0, time_q} + 8'd30;
    assign add_sat   = add_sum[7] ? 7'd127 : add_sum[6:0];

`ifdef COOK_ADD30_EN
    // Holding start must add only once, so we act on its rising edge.
    logic start_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) start_prev <= 1'b0;
        else        start_prev <= start_button;
    end

    assign add_req = start_button && !start_prev;
`else
    assign add_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. Priority: cancel > door open > start > tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_req) state_d = ST_COOK;
            ST_COOK: begin
                if (cancel_button)     state_d = ST_IDLE;
                else if (!door_status) state_d = ST_PAUSE;
                else if (tick_wrap && !add_req && time_q == 7'd1) state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (cancel_button)                    state_d = ST_IDLE;
                else if (door_status && start_button) state_d = ST_COOK;
            end
            ST_DONE:  if (cancel_button || !door_status) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs. The door term is combinational so the magnetron drops in the
    // same cycle the door opens, ahead of the PAUSE transition.
    always_comb begin
        magnetron_on = (state_q == ST_COOK) && door_status &&
                       (power || (duty_phase < DW'(DUTY_PERIOD / 2)));
    end

    assign state          = state_q;
    assign time_remaining = time_q;
    assign done_pulse     = done_q;

    // Datapath: countdown, tick counter and duty phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_q     <= '0;
            tick_cnt   <= '0;
            duty_phase <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_req) begin
                        time_q     <= timer;
                        tick_cnt   <= '0;
                        duty_phase <= '0;
                    end
                end
                ST_COOK: begin
                    if (cancel_button) begin
                        time_q <= '0;
                    end else if (door_status) begin
                        // An open door takes the else path: all counters hold,
                        // including a wrap that lands in the same cycle.
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
                        if (tick_wrap)
                            duty_phase <= (duty_phase == DW'(DUTY_PERIOD - 1)) ?
                                          '0 : duty_phase + DW'(1);
                        // An add outranks the decrement of the same cycle.
                        if (add_req) begin
                            time_q <= add_sat;
                        end else if (tick_wrap && time_q != 7'd0) begin
                            time_q <= time_q - 7'd1;
                            if (time_q == 7'd1) done_q <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cancel_button) time_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cook_sequencer.sv
module tb_cook_sequencer;
    localparam int TPS = 1;
    localparam int DP  = 10;

    logic       clk = 1'b0;
    logic       rst_n, power, door_status, start_button, cancel_button;
    logic [6:0] timer;
    logic       magnetron_on, done_pulse;
    logic [6:0] time_remaining;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state as 0..3, seconds left, cycles into the current
    // second, whole seconds cooked since start (duty = seconds mod DP).
    int m_state, m_rem, m_cyc, m_sec;
    bit m_done, m_prev;

    cook_sequencer #(.TICKS_PER_SEC(TPS), .DUTY_PERIOD(DP)) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .timer(timer),
        .door_status(door_status), .start_button(start_button),
        .cancel_button(cancel_button), .magnetron_on(magnetron_on),
        .time_remaining(time_remaining), .state(state), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit d, input bit s, input bit c, input int t);
        bit add, wrap;
`ifdef COOK_ADD30_EN
        add = s && !m_prev;
`else
        add = 1'b0;
`endif
        m_done = 1'b0;
        if (!r) begin
            m_state = 0; m_rem = 0; m_cyc = 0; m_sec = 0; m_prev = 1'b0;
            return;
        end
        m_prev = s;
        case (m_state)
            0: if (!c && s && d && t != 0) begin
                m_state = 1; m_rem = t; m_cyc = 0; m_sec = 0;
            end
            1: begin
                if (c) begin
                    m_state = 0; m_rem = 0;
                end else if (!d) begin
                    m_state = 2;
                end else begin
                    m_cyc++;
                    wrap = (m_cyc == TPS);
                    if (wrap) begin m_cyc = 0; m_sec++; end
                    if (add) m_rem = (m_rem + 30 > 127) ? 127 : m_rem + 30;
                    else if (wrap) begin
                        m_rem--;
                        if (m_rem == 0) begin m_state = 3; m_done = 1'b1; end
                    end
                end
            end
            2: begin
                if (c) begin m_state = 0; m_rem = 0; end
                else if (d && s) m_state = 1;
            end
            default: if (c || !d) m_state = 0;
        endcase
    endtask

    // Drive one cycle of inputs, check the combinational output before the
    // edge, then the registered outputs after it.
    task automatic cyc(input bit r, input bit p, input bit d, input bit s, input bit c, input int t);
        rst_n = r; power = p; door_status = d; start_button = s; cancel_button = c;
        timer = t[6:0];
        #1;
        chk("magnetron_on", magnetron_on,
            32'(m_state == 1 && d && (p || (m_sec % DP) < DP / 2)));
        @(posedge clk);
        model_step(r, d, s, c, t);
        @(negedge clk);
        chk("state", state, m_state);
        chk("time_remaining", time_remaining, m_rem);
        chk("done_pulse", done_pulse, m_done);
    endtask

    initial begin
        m_state = 0; m_rem = 0; m_cyc = 0; m_sec = 0; m_done = 0; m_prev = 0;

        // Reset
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 9);
        chk("reset_state", state, 0);
        chk("reset_time", time_remaining, 0);

        // Full cook at full power
        cyc(1, 1, 1, 1, 0, 5);
        chk("full_start", state, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 5);
        chk("full_done_state", state, 3);
        chk("full_done_pulse", done_pulse, 1);
        cyc(1, 1, 1, 1, 0, 5);          // start ignored in DONE
        chk("done_pulse_once", done_pulse, 0);
        cyc(1, 1, 0, 0, 0, 5);          // door open -> IDLE
        chk("done_to_idle", state, 0);

        // Half-power duty, power forced to full mid-window
        cyc(1, 0, 1, 1, 0, 20);
        for (int i = 0; i < 20; i++) begin
            cyc(1, (i == 7) ? 1'b1 : 1'b0, 1, 0, 0, 20);
            if (i == 7) chk("power_override", m_state, 1);
        end
        cyc(1, 0, 1, 0, 1, 0);          // leave DONE via cancel

        // Door pause / resume
        cyc(1, 1, 1, 1, 0, 100);
        for (int i = 0; i < 30; i++) cyc(1, 1, 1, 0, 0, 100);
        cyc(1, 1, 0, 0, 0, 100);
        chk("pause_state", state, 2);
        chk("pause_time", time_remaining, 70);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 50);
        chk("closed_no_resume", state, 2);
        cyc(1, 1, 1, 1, 0, 50);
        chk("resume_time", time_remaining, 70);
        for (int i = 0; i < 70; i++) cyc(1, 1, 1, 0, 0, 50);
        chk("resume_done", state, 3);
        cyc(1, 1, 0, 0, 0, 0);

        // Guards
        cyc(1, 1, 0, 1, 0, 10);
        chk("door_open_start", state, 0);
        cyc(1, 1, 1, 1, 0, 0);
        chk("zero_timer_start", state, 0);
        cyc(1, 1, 1, 1, 1, 10);
        chk("idle_start_cancel", state, 0);
        cyc(1, 1, 1, 1, 0, 10);
        cyc(1, 1, 1, 0, 0, 10);
        cyc(1, 1, 0, 0, 0, 10);
        cyc(1, 1, 1, 1, 1, 10);
        chk("pause_cancel_state", state, 0);
        chk("pause_cancel_time", time_remaining, 0);

        // Reset mid-cook
        cyc(1, 1, 1, 1, 0, 60);
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 0, 60);
        chk("pre_reset_time", time_remaining, 40);
        cyc(0, 1, 1, 0, 0, 60);
        chk("mid_reset_state", state, 0);
        cyc(1, 1, 1, 0, 0, 60);

`ifdef COOK_ADD30_EN
        cyc(1, 1, 1, 1, 0, 115);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 115);
        chk("pre_add_time", time_remaining, 110);
        cyc(1, 1, 1, 1, 0, 115);
        chk("add_saturate", time_remaining, 127);
        cyc(1, 1, 1, 0, 0, 115);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, 115);
        chk("held_start_once", time_remaining, 125);
        cyc(1, 1, 1, 0, 1, 0);
`endif

        // Randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 29) == 0, int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
